// File: rtl/alu_issue_queue.sv
// In-order operand-collecting issue queue feeding the single-cycle integer ALU.
// Define ALU_IQ_BYPASS_EN to let an op arriving at an empty queue issue in the same cycle.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [7:0]               enq_aluop,
    input  logic                     enq_src1_rdy,
    input  logic [TAG_W-1:0]         enq_src1_tag,
    input  logic [31:0]              enq_src1_val,
    input  logic                     enq_src2_rdy,
    input  logic [TAG_W-1:0]         enq_src2_tag,
    input  logic [31:0]              enq_src2_val,
    input  logic [TAG_W-1:0]         enq_dst_tag,
    input  logic                     wb_valid,
    input  logic [TAG_W-1:0]         wb_tag,
    input  logic [31:0]              wb_data,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [7:0]               iss_aluop,
    output logic [31:0]              iss_reg1,
    output logic [31:0]              iss_reg2,
    output logic [TAG_W-1:0]         iss_dst_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             valid;
        logic [7:0]       aluop;
        logic             rdy1;
        logic [TAG_W-1:0] tag1;
        logic [31:0]      val1;
        logic             rdy2;
        logic [TAG_W-1:0] tag2;
        logic [31:0]      val2;
        logic [TAG_W-1:0] dst;
    } entry_t;

    entry_t           entries_q [DEPTH];
    entry_t           entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    entry_t           incoming;
    logic             bypassSel;
    logic             enqFire, issFire, enqWrite, popHead;
    logic             selReady;
    logic [7:0]       selAluop;
    logic [31:0]      selVal1, selVal2;
    logic [TAG_W-1:0] selDst;

    // Incoming op with same-cycle writeback folded in, so a broadcast is never missed.
    always_comb begin
        incoming       = '0;
        incoming.valid = 1'b1;
        incoming.aluop = enq_aluop;
        incoming.rdy1  = enq_src1_rdy || (wb_valid && (wb_tag == enq_src1_tag));
        incoming.tag1  = enq_src1_tag;
        incoming.val1  = enq_src1_rdy ? enq_src1_val : wb_data;
        incoming.rdy2  = enq_src2_rdy || (wb_valid && (wb_tag == enq_src2_tag));
        incoming.tag2  = enq_src2_tag;
        incoming.val2  = enq_src2_rdy ? enq_src2_val : wb_data;
        incoming.dst   = enq_dst_tag;
    end

`ifdef ALU_IQ_BYPASS_EN
    assign bypassSel = !rst && !flush && (count_q == '0) && enq_valid
                       && incoming.rdy1 && incoming.rdy2;
`else
    assign bypassSel = 1'b0;
`endif

    // A flushed head is never offered, so wrong-path ops cannot reach the ALU.
    always_comb begin
        selReady = !rst && !flush && entries_q[head_q].valid
                   && entries_q[head_q].rdy1 && entries_q[head_q].rdy2;
        selAluop = entries_q[head_q].aluop;
        selVal1  = entries_q[head_q].val1;
        selVal2  = entries_q[head_q].val2;
        selDst   = entries_q[head_q].dst;
        if (bypassSel) begin
            selReady = 1'b1;
            selAluop = incoming.aluop;
            selVal1  = incoming.val1;
            selVal2  = incoming.val2;
            selDst   = incoming.dst;
        end
    end

    assign enq_ready   = !rst && (count_q < CNT_W'(DEPTH));
    assign iss_valid   = selReady;
    assign iss_aluop   = selReady ? selAluop : '0;
    assign iss_reg1    = selReady ? selVal1  : '0;
    assign iss_reg2    = selReady ? selVal2  : '0;
    assign iss_dst_tag = selReady ? selDst   : '0;
    assign count       = count_q;

    assign enqFire  = enq_valid && enq_ready;
    assign issFire  = iss_valid && iss_ready;
    assign enqWrite = enqFire && !(bypassSel && iss_ready);
    assign popHead  = issFire && !bypassSel;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (wb_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entries_q[i].valid && !entries_q[i].rdy1 && (entries_q[i].tag1 == wb_tag)) begin
                        entries_d[i].rdy1 = 1'b1;
                        entries_d[i].val1 = wb_data;
                    end
                    if (entries_q[i].valid && !entries_q[i].rdy2 && (entries_q[i].tag2 == wb_tag)) begin
                        entries_d[i].rdy2 = 1'b1;
                        entries_d[i].val2 = wb_data;
                    end
                end
            end
            if (popHead) begin
                entries_d[head_q].valid = 1'b0;
                head_d = head_q + PTR_W'(1);
            end
            // Enqueue is blocked when full, so tail never lands on the slot being popped.
            if (enqWrite) begin
                entries_d[tail_q] = incoming;
                tail_d = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enqWrite) - CNT_W'(popHead);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
